// File: rtl/data_mem_responder.sv
// Fixed-latency data-memory responder for the MEM-stage load/store port.
// Optional DMEM_OOR_CHECK_EN: addresses >= DEPTH fault instead of wrapping.
module data_mem_responder #(
    parameter int DATA_W  = 16,
    parameter int ADDR_W  = 16,
    parameter int DEPTH   = 256,
    parameter int LATENCY = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              mem_r_en,
    input  logic              mem_w_en,
    input  logic [ADDR_W-1:0] addr,
    input  logic [DATA_W-1:0] wdata,
    output logic              freeze,
    output logic              resp_valid,
    output logic [DATA_W-1:0] rdata,
    output logic              err
);
    localparam int IDX_W = $clog2(DEPTH);

    typedef enum logic [1:0] {S_IDLE, S_BUSY, S_DONE} state_t;

    state_t            r_state, w_next;
    logic [3:0]        r_cnt;
    logic [ADDR_W-1:0] r_addr;
    logic [DATA_W-1:0] r_wdata;
    logic              r_is_st;
    logic [DATA_W-1:0] r_rdata;
    logic              r_resp_valid;
    logic              r_err;
    logic [DATA_W-1:0] r_mem [DEPTH];

    logic              w_req;
    logic              w_last;
    logic              w_oor;
    logic [IDX_W-1:0]  w_idx;

    assign w_req  = mem_r_en | mem_w_en;
    assign w_last = (r_state == S_BUSY) && (r_cnt == 4'd0);
    assign w_idx  = r_addr[IDX_W-1:0];

`ifdef DMEM_OOR_CHECK_EN
    // DEPTH is a power of two, so any set bit above the index is out of range.
    assign w_oor = |r_addr[ADDR_W-1:IDX_W];
`else
    assign w_oor = 1'b0;
`endif

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:  if (w_req) w_next = S_BUSY;
            S_BUSY:  if (r_cnt == 4'd0) w_next = S_DONE;
            S_DONE:  w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    // Held low during reset so an aborted access never stalls the pipeline.
    assign freeze = !rst && (((r_state == S_IDLE) && w_req) || (r_state == S_BUSY));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_state <= S_IDLE;
        else     r_state <= w_next;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cnt        <= 4'd0;
            r_addr       <= '0;
            r_wdata      <= '0;
            r_is_st      <= 1'b0;
            r_rdata      <= '0;
            r_resp_valid <= 1'b0;
            r_err        <= 1'b0;
            for (int i = 0; i < DEPTH; i++) r_mem[i] <= '0;
        end else begin
            r_resp_valid <= 1'b0;
            r_err        <= 1'b0;
            if (r_state == S_IDLE && w_req) begin
                r_addr  <= addr;
                r_wdata <= wdata;
                r_is_st <= mem_w_en;  // a store wins when both enables are high
                r_cnt   <= 4'(LATENCY - 1);
            end
            if (r_state == S_BUSY && r_cnt != 4'd0) r_cnt <= r_cnt - 4'd1;
            if (w_last) begin
                r_resp_valid <= 1'b1;
                r_err        <= w_oor;
                if (r_is_st) begin
                    if (!w_oor) r_mem[w_idx] <= r_wdata;
                end else begin
                    r_rdata <= w_oor ? '0 : r_mem[w_idx];
                end
            end
        end
    end

    assign resp_valid = r_resp_valid;
    assign err        = r_err;
    assign rdata      = r_rdata;
endmodule

// File: tb/tb_data_mem_responder.sv
// Directed bench for data_mem_responder (LATENCY=2, DEPTH=256).
module tb_data_mem_responder;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        mem_r_en = 1'b0;
    logic        mem_w_en = 1'b0;
    logic [15:0] addr = '0;
    logic [15:0] wdata = '0;
    logic        freeze;
    logic        resp_valid;
    logic [15:0] rdata;
    logic        err;

    int total = 0;
    int bad   = 0;

    data_mem_responder #(.DATA_W(16), .ADDR_W(16), .DEPTH(256), .LATENCY(2)) dut (
        .clk(clk), .rst(rst), .mem_r_en(mem_r_en), .mem_w_en(mem_w_en),
        .addr(addr), .wdata(wdata), .freeze(freeze), .resp_valid(resp_valid),
        .rdata(rdata), .err(err)
    );

    always #5 clk = ~clk;

    // Presents a request held until resp_valid, like a frozen pipeline.
    // Cycle 1 is the cycle the request first appears; rcyc=0 means timeout.
    task automatic access(input logic r, input logic w, input logic [15:0] a,
                          input logic [15:0] d, output int nfrz, output int rcyc,
                          output logic [15:0] rd, output logic e);
        @(negedge clk);
        mem_r_en = r; mem_w_en = w; addr = a; wdata = d;
        #1;
        nfrz = 0; rcyc = 0; rd = 'x; e = 1'bx;
        for (int c = 1; c <= 20; c++) begin
            if (c > 1) @(negedge clk);
            if (freeze) nfrz++;
            if (resp_valid) begin
                rcyc = c; rd = rdata; e = err;
                break;
            end
        end
        mem_r_en = 1'b0; mem_w_en = 1'b0;
    endtask

    task automatic test_reset();
        int nf, rc; logic [15:0] rd; logic e;
        @(negedge clk); rst = 1'b0;
        @(negedge clk); mem_r_en = 1'b1; addr = 16'd5;
        @(posedge clk); #2; rst = 1'b1; #1;
        total++; if (freeze !== 1'b0) begin bad++; $display("FAIL reset_freeze: got %b want 0", freeze); end
        total++; if (resp_valid !== 1'b0) begin bad++; $display("FAIL reset_resp_valid: got %b want 0", resp_valid); end
        total++; if (rdata !== 16'h0000) begin bad++; $display("FAIL reset_rdata: got %h want 0000", rdata); end
        total++; if (err !== 1'b0) begin bad++; $display("FAIL reset_err: got %b want 0", err); end
        @(negedge clk); mem_r_en = 1'b0; rst = 1'b0;
        access(1'b1, 1'b0, 16'd5, 16'h0, nf, rc, rd, e);
        total++; if (rc !== 4) begin bad++; $display("FAIL reset_load_latency: got %0d want 4", rc); end
        total++; if (rd !== 16'h0000) begin bad++; $display("FAIL reset_load_rdata: got %h want 0000", rd); end
    endtask

    task automatic test_store_load();
        int nf, rc; logic [15:0] rd; logic e;
        access(1'b0, 1'b1, 16'h0012, 16'hBEEF, nf, rc, rd, e);
        total++; if (nf !== 3) begin bad++; $display("FAIL st_freeze_cycles: got %0d want 3", nf); end
        total++; if (rc !== 4) begin bad++; $display("FAIL st_resp_cycle: got %0d want 4", rc); end
        total++; if (rd !== 16'h0000) begin bad++; $display("FAIL st_rdata_kept: got %h want 0000", rd); end
        total++; if (e !== 1'b0) begin bad++; $display("FAIL st_err: got %b want 0", e); end
        @(negedge clk);
        total++; if (resp_valid !== 1'b0) begin bad++; $display("FAIL st_pulse_width: got %b want 0", resp_valid); end
        access(1'b1, 1'b0, 16'h0012, 16'h0, nf, rc, rd, e);
        total++; if (nf !== 3) begin bad++; $display("FAIL ld_freeze_cycles: got %0d want 3", nf); end
        total++; if (rc !== 4) begin bad++; $display("FAIL ld_resp_cycle: got %0d want 4", rc); end
        total++; if (rd !== 16'hBEEF) begin bad++; $display("FAIL ld_rdata: got %h want beef", rd); end
    endtask

    task automatic test_back_to_back();
        int nf, rc; logic [15:0] rd; logic e;
        access(1'b0, 1'b1, 16'd3, 16'h1111, nf, rc, rd, e);
        total++; if (nf !== 3 || rc !== 4) begin bad++; $display("FAIL b2b_st3_timing: got frz=%0d resp=%0d want 3/4", nf, rc); end
        access(1'b0, 1'b1, 16'd4, 16'h2222, nf, rc, rd, e);
        total++; if (nf !== 3 || rc !== 4) begin bad++; $display("FAIL b2b_st4_timing: got frz=%0d resp=%0d want 3/4", nf, rc); end
        total++; if (rd !== 16'hBEEF) begin bad++; $display("FAIL b2b_rdata_kept: got %h want beef", rd); end
        access(1'b1, 1'b0, 16'd3, 16'h0, nf, rc, rd, e);
        total++; if (rd !== 16'h1111) begin bad++; $display("FAIL b2b_ld3: got %h want 1111", rd); end
        access(1'b1, 1'b0, 16'd4, 16'h0, nf, rc, rd, e);
        total++; if (rd !== 16'h2222) begin bad++; $display("FAIL b2b_ld4: got %h want 2222", rd); end
    endtask

    task automatic test_both_en();
        int nf, rc; logic [15:0] rd; logic e;
        access(1'b1, 1'b1, 16'd7, 16'h00AA, nf, rc, rd, e);
        total++; if (rc !== 4) begin bad++; $display("FAIL both_resp_cycle: got %0d want 4", rc); end
        total++; if (rd !== 16'h2222) begin bad++; $display("FAIL both_rdata_kept: got %h want 2222", rd); end
        access(1'b1, 1'b0, 16'd7, 16'h0, nf, rc, rd, e);
        total++; if (rd !== 16'h00AA) begin bad++; $display("FAIL both_ld7: got %h want 00aa", rd); end
    endtask

    task automatic test_reset_mid();
        int nf, rc; logic [15:0] rd; logic e;
        int pulses;
        pulses = 0;
        @(negedge clk); mem_w_en = 1'b1; addr = 16'd9; wdata = 16'h5555;
        @(negedge clk);
        if (resp_valid) pulses++;
        #2; rst = 1'b1; #1;
        total++; if (freeze !== 1'b0) begin bad++; $display("FAIL mid_freeze: got %b want 0", freeze); end
        for (int i = 0; i < 2; i++) begin @(negedge clk); if (resp_valid) pulses++; end
        mem_w_en = 1'b0; rst = 1'b0;
        for (int i = 0; i < 4; i++) begin @(negedge clk); if (resp_valid) pulses++; end
        total++; if (pulses !== 0) begin bad++; $display("FAIL mid_no_resp: got %0d pulses want 0", pulses); end
        total++; if (rdata !== 16'h0000) begin bad++; $display("FAIL mid_rdata_reset: got %h want 0000", rdata); end
        access(1'b1, 1'b0, 16'd9, 16'h0, nf, rc, rd, e);
        total++; if (rc !== 4) begin bad++; $display("FAIL mid_ld_resp: got %0d want 4", rc); end
        total++; if (rd !== 16'h0000) begin bad++; $display("FAIL mid_ld9: got %h want 0000", rd); end
    endtask

    task automatic test_wrap();
        int nf, rc; logic [15:0] rd; logic e;
        logic        exp_err;
        logic [15:0] exp_data;
`ifdef DMEM_OOR_CHECK_EN
        exp_err = 1'b1; exp_data = 16'h0000;
`else
        exp_err = 1'b0; exp_data = 16'h7777;
`endif
        access(1'b0, 1'b1, 16'h0105, 16'h7777, nf, rc, rd, e);
        total++; if (nf !== 3 || rc !== 4) begin bad++; $display("FAIL wrap_st_timing: got frz=%0d resp=%0d want 3/4", nf, rc); end
        total++; if (e !== exp_err) begin bad++; $display("FAIL wrap_st_err: got %b want %b", e, exp_err); end
        @(negedge clk);
        total++; if (err !== 1'b0) begin bad++; $display("FAIL wrap_err_width: got %b want 0", err); end
        access(1'b1, 1'b0, 16'd5, 16'h0, nf, rc, rd, e);
        total++; if (rd !== exp_data) begin bad++; $display("FAIL wrap_ld5: got %h want %h", rd, exp_data); end
        total++; if (e !== 1'b0) begin bad++; $display("FAIL wrap_ld5_err: got %b want 0", e); end
        access(1'b1, 1'b0, 16'h0105, 16'h0, nf, rc, rd, e);
        total++; if (rd !== exp_data) begin bad++; $display("FAIL wrap_ld105: got %h want %h", rd, exp_data); end
        total++; if (e !== exp_err) begin bad++; $display("FAIL wrap_ld105_err: got %b want %b", e, exp_err); end
    endtask

    initial begin
        test_reset();
        test_store_load();
        test_back_to_back();
        test_both_en();
        test_reset_mid();
        test_wrap();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
